// File: rtl/smac_pkg.sv
// Shared constants and helpers for the packed SIMD sub-MAC (smac_simd).
// Saturation behaviour of the lane slices is selected by the SMAC_SAT_EN macro.
package smac_pkg;

  localparam logic [3:0] PREC_INT8  = 4'b0001;
  localparam logic [3:0] PREC_INT16 = 4'b0010;
  localparam logic [3:0] PREC_INT32 = 4'b0100;
  localparam logic [3:0] PREC_INT64 = 4'b1000;

  localparam int SMAC_LATENCY = 3;

  function automatic int lanes(input int data_w, input logic [3:0] prec);
    case (prec)
      PREC_INT8:  return data_w / 8;
      PREC_INT16: return data_w / 16;
      PREC_INT32: return data_w / 32;
      PREC_INT64: return data_w / 64;
      default:    return 0;
    endcase
  endfunction

  // True when a full-precision signed sum does not fit in a w-bit signed lane.
  function automatic logic sat_hit(input logic signed [128:0] sum, input int w);
    logic signed [128:0] hi;
    logic signed [128:0] lo;
    hi = (129'sd1 <<< (w - 1)) - 129'sd1;
    lo = -(129'sd1 <<< (w - 1));
    return (sum > hi) || (sum < lo);
  endfunction

endpackage

// File: rtl/smac_lane_slice.sv
// One signed lane of width W: registered full product (S2) and combinational add/reduce (S3).
// SMAC_SAT_EN selects clamp-with-flag; otherwise the lane wraps modulo 2^W.
module smac_lane_slice
  import smac_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         ce,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] addend,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic signed [2*W-1:0] a_ext;
  logic signed [2*W-1:0] b_ext;
  logic signed [2*W-1:0] prod_reg;
  logic [2*W:0]          sum_full;

  assign a_ext = {{W{a[W-1]}}, a};
  assign b_ext = {{W{b[W-1]}}, b};

  always_ff @(posedge clk) begin
    if (ce) prod_reg <= a_ext * b_ext;
  end

  // One extra bit keeps product + addend exact before reduction.
  assign sum_full = {prod_reg[2*W-1], prod_reg} + {{(W+1){addend[W-1]}}, addend};

`ifdef SMAC_SAT_EN
  logic hit;
  assign hit = sat_hit(129'($signed(sum_full)), W);
  assign sum = hit ? (sum_full[2*W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                   : sum_full[W-1:0];
  assign ovf = hit;
`else
  logic unused_hi;
  assign unused_hi = ^sum_full[2*W:W];
  assign sum = sum_full[W-1:0];
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/smac_simd.sv
// Packed multi-precision MAC, 3-stage valid-tagged pipeline with optional local accumulation.
// Define SMAC_SAT_EN for saturating lanes with per-lane overflow flags.
module smac_simd
  import smac_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic                 clk,
  input  logic                 sclr,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    data_input,
  input  logic [DATA_W-1:0]    weight,
  input  logic [DATA_W-1:0]    res_mac_p,
  input  logic [3:0]           select_precision,
  input  logic                 acc_mode,
  input  logic                 acc_clear,
  output logic [DATA_W-1:0]    res_mac_n,
  output logic                 out_valid,
  output logic [DATA_W/8-1:0]  overflow
);

  localparam int NLANE8 = DATA_W / 8;

  logic              accept;
  logic              s1_valid_reg, s2_valid_reg, out_valid_reg;
  logic [DATA_W-1:0] s1_data_reg, s1_weight_reg, s1_resp_reg, s2_resp_reg;
  logic [3:0]        s1_prec_reg, s2_prec_reg;
  logic              s1_mode_reg, s1_clear_reg, s2_mode_reg, s2_clear_reg;
  logic [DATA_W-1:0] res_mac_n_reg;
  logic [NLANE8-1:0] overflow_reg;

  logic [DATA_W-1:0] addend_word;
  logic [DATA_W-1:0] sum_by_prec [4];
  logic [NLANE8-1:0] ovf_by_prec [4];
  logic [DATA_W-1:0] sel_sum;
  logic [NLANE8-1:0] sel_ovf;

  assign accept = ce & in_valid & $onehot(select_precision);

  // Feedback reads the result register directly, so back-to-back accumulation needs no bypass.
  always_comb begin
    addend_word = s2_resp_reg;
    if (s2_clear_reg)     addend_word = '0;
    else if (s2_mode_reg) addend_word = res_mac_n_reg;
  end

  for (genvar wi = 0; wi < 4; wi++) begin : g_prec
    localparam logic [3:0] PREC = 4'(1 << wi);
    localparam int NL = lanes(DATA_W, PREC);
    localparam int W  = DATA_W / NL;
    logic [DATA_W-1:0] sum_w;
    logic [NL-1:0]     ovf_l;

    for (genvar gi = 0; gi < NL; gi++) begin : g_lane
      smac_lane_slice #(.W(W)) u_slice (
        .clk    (clk),
        .ce     (ce),
        .a      (s1_data_reg[gi*W +: W]),
        .b      (s1_weight_reg[gi*W +: W]),
        .addend (addend_word[gi*W +: W]),
        .sum    (sum_w[gi*W +: W]),
        .ovf    (ovf_l[gi])
      );
    end

    assign sum_by_prec[wi] = sum_w;
    assign ovf_by_prec[wi] = NLANE8'(ovf_l);
  end

  always_comb begin
    sel_sum = '0;
    sel_ovf = '0;
    for (int i = 0; i < 4; i++) begin
      if (s2_prec_reg[i]) begin
        sel_sum = sum_by_prec[i];
        sel_ovf = ovf_by_prec[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      s1_valid_reg  <= 1'b0;
      s2_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      res_mac_n_reg <= '0;
      overflow_reg  <= '0;
    end else if (ce) begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_data_reg   <= data_input;
        s1_weight_reg <= weight;
        s1_resp_reg   <= res_mac_p;
        s1_prec_reg   <= select_precision;
        s1_mode_reg   <= acc_mode;
        s1_clear_reg  <= acc_clear;
      end
      s2_valid_reg <= s1_valid_reg;
      s2_resp_reg  <= s1_resp_reg;
      s2_prec_reg  <= s1_prec_reg;
      s2_mode_reg  <= s1_mode_reg;
      s2_clear_reg <= s1_clear_reg;
      out_valid_reg <= s2_valid_reg;
      if (s2_valid_reg) begin
        res_mac_n_reg <= sel_sum;
        overflow_reg  <= sel_ovf;
      end
    end
  end

  assign res_mac_n = res_mac_n_reg;
  assign out_valid = out_valid_reg;
  assign overflow  = overflow_reg;

endmodule

// File: doc/smac_simd.md
# smac_simd

Parametrised successor of the single-lane sub-MAC. It packs several signed integer lanes (int8/int16/int32/int64) into one `DATA_W`-bit word and computes `res_mac_n = res_mac_p + data_input * weight` per lane through a 3-stage valid-tagged pipeline. It can also accumulate locally instead of taking the chained partial sum. It sits in the DTPU systolic array in place of a per-precision sub-MAC instance, fed by the weight/activation staging logic and chained to its neighbour via `res_mac_p`/`res_mac_n`.

## Interface
Parameters:
- `DATA_W`, 64: datapath width; must be a multiple of 64.
- `NLANE8`, `DATA_W/8`: derived, not overridable; lane count at int8, also the width of `overflow`.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `sclr`  in  1  synchronous, active-high reset; overrides `ce`.
- `ce`  in  1  clock enable; low freezes every register, including valid bits.
- `in_valid`  in  1  transaction present on the inputs this cycle.
- `data_input`  in  DATA_W  packed activations; lane k occupies bits [k*W +: W].
- `weight`  in  DATA_W  packed weights, same packing.
- `res_mac_p`  in  DATA_W  packed chained partial sum (addend).
- `select_precision`  in  4  one-hot: bit0 int8, bit1 int16, bit2 int32, bit3 int64.
- `acc_mode`  in  1  addend = internal accumulator instead of `res_mac_p`.
- `acc_clear`  in  1  with `acc_mode`: addend = 0 for this transaction.
- `res_mac_n`  out  DATA_W  packed lane results; reset 0.
- `out_valid`  out  1  `res_mac_n` updated this cycle; reset 0.
- `overflow`  out  NLANE8  per-lane overflow flag; bit k = lane k; bits at or above the lane count are 0. Reset 0.

## Operation
- Accept rule: a transaction is accepted when `ce & in_valid & onehot(select_precision)`. A non-one-hot select discards the transaction: no `out_valid` and no state change.
- S1 registers the operands, precision, `acc_mode` and `acc_clear`. Precision travels with the data, so mixed precisions in flight are legal.
- S2 forms the full signed per-lane product (2W bits) for the tagged precision.
- S3 adds the addend and writes `res_mac_n`.
  - Addend selection: `acc_clear` gives 0; else `acc_mode` gives the current `res_mac_n` register (feedback); else the S1-registered `res_mac_p`.
  - This makes back-to-back accumulation hazard-free.
- Arithmetic: signed two's complement per lane. The sum is computed at full precision, then reduced to W bits (wrap or saturate, see Configuration).
- Precision change while accumulating: the accumulator bits are reinterpreted at the new lane width with no conversion. Software must issue `acc_clear`.
- `res_mac_n` and `overflow` hold their values when S3 holds no valid transaction.

## Timing
- Latency: exactly 3 `ce`-high cycles. Input accepted at edge t gives `out_valid` high during the cycle after edge t+2, with `ce` continuously high.
- Throughput: 1 transaction per `ce`-high cycle; no backpressure.
- `ce` low: the pipeline freezes and `out_valid` holds its value; the downstream consumer must qualify `out_valid` with `ce`.
- `sclr`: next edge clears all valid bits, `res_mac_n`, `overflow` and the accumulator. In-flight transactions are dropped and no `out_valid` is produced for them.
- `sclr` together with `in_valid`: reset wins and the input is dropped.

## Configuration
- `SMAC_SAT_EN` defined: each lane sum is clamped to [-2^(W-1), 2^(W-1)-1]. `overflow[k]` is set with the result when clamping occurred.
- `SMAC_SAT_EN` undefined: each lane wraps modulo 2^W, and `overflow` is tied to 0.

## Structure
- Package `smac_pkg`:
  - precision one-hot constants `PREC_INT8/16/32/64`
  - `SMAC_LATENCY = 3`
  - lane-count function `lanes(DATA_W, prec)`
  - saturation helper function.
- Sub-module `smac_lane_slice #(W)`: one lane's S2 product plus S3 add/saturate.
  - Generated for every lane position at each of the 4 widths.
  - The top-level muxes the results by the S3 precision tag.

## Test plan
- int8, DATA_W=64: all lanes data 0x03, weight 0x02, `res_mac_p` 0x01 → 3 cycles later `res_mac_n`=0x0707070707070707, single-cycle `out_valid`.
- int16 signed: lane0 data 0xFFFF, weight 0x0005, `res_mac_p` 0x000A → lane0 = 0x0005; other lanes 0 with zero inputs.
- `ce` stall: accept at cycle 0, `ce` low cycles 1–2 → `out_valid` at cycle 5; `res_mac_n` is stable throughout the stall.
- int32 accumulate:
  - `acc_clear` with data 2, weight 3;
  - then four back-to-back `acc_mode` transactions with data 1, weight 1;
  - lane0 results 6, 7, 8, 9, 10 on consecutive cycles.
- int8 lane0: data 0x01, weight 0x01, `res_mac_p` 0x7F → with `SMAC_SAT_EN`: 0x7F and `overflow[0]`=1; without: 0x80 and `overflow`=0.
- Reset mid-flight: accept at cycles 0 and 1, `sclr` at cycle 2 → no `out_valid`; `res_mac_n`=0 and `overflow`=0; a non-one-hot select (4'b0011) with `in_valid` produces no `out_valid`.
